// File: rtl/cla_pkg.sv
// Shared definitions for the sequential chunked carry-lookahead adder.
// Holds the FSM state encoding, the default slice width and the
// signed-overflow helper used when the final chunk completes.
package cla_pkg;

  localparam int CHUNK_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's-complement overflow: operands share a sign the result does not.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla_slice.sv
// Purely combinational CHUNK-bit carry-lookahead adder slice.
// Every carry is a flat sum of generate terms gated by propagate chains,
// so no carry ripples through the lower bits of the slice.
module cla_slice #(
  parameter int CHUNK = 16
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] g;
  logic [CHUNK-1:0] p;
  logic [CHUNK:0]   c;
  logic             run_p;

  assign g = a & b;
  assign p = a ^ b;

  // Lookahead carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]cin.
  always_comb begin
    c     = {(CHUNK+1){1'b0}};
    run_p = 1'b0;
    c[0]  = cin;
    for (int i = 0; i < CHUNK; i++) begin
      c[i+1] = g[i];
      run_p  = p[i];
      for (int j = i - 1; j >= 0; j--) begin
        c[i+1] = c[i+1] | (run_p & g[j]);
        run_p  = run_p & p[j];
      end
      c[i+1] = c[i+1] | (run_p & cin);
    end
  end

  assign sum  = p ^ c[CHUNK-1:0];
  assign cout = c[CHUNK];

endmodule

// File: rtl/cla_wide_seq.sv
// WIDTH-bit adder that processes one CHUNK-bit lookahead slice per cycle.
// Operands are latched on acceptance, a carry register links the chunks,
// and the result is held in DONE until the consumer takes it.
// Optional feature macro: CLA_SEQ_SUB_EN (enables subtract via the sub port).
module cla_wide_seq
  import cla_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = CHUNK_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = $clog2(NCHUNK);
  localparam logic [CW-1:0] LAST = CW'(NCHUNK - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opa_nxt;
  logic [WIDTH-1:0] opb;
  logic [WIDTH-1:0] opb_nxt;
  logic             carry;
  logic             carry_nxt;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             cout_nxt;
  logic             ovf_nxt;

  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;
  logic [CHUNK-1:0] chunk_a;
  logic [CHUNK-1:0] chunk_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;
  logic [WIDTH-1:0] sum_merged;

`ifdef CLA_SEQ_SUB_EN
  // Subtraction is a + ~b + 1; the incoming cin is ignored in that case.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  logic unused_sub;
  assign b_eff      = b;
  assign cin_eff    = cin;
  assign unused_sub = sub;
`endif

  // Status outputs decode straight from the state register.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  // Select the active operand chunk and splice the slice result into sum.
  always_comb begin
    chunk_a    = opa[CHUNK-1:0];
    chunk_b    = opb[CHUNK-1:0];
    sum_merged = sum;
    for (int k = 0; k < NCHUNK; k++) begin
      if (cnt == CW'(k)) begin
        chunk_a                       = opa[k*CHUNK +: CHUNK];
        chunk_b                       = opb[k*CHUNK +: CHUNK];
        sum_merged[k*CHUNK +: CHUNK]  = slice_sum;
      end else begin
        sum_merged[k*CHUNK +: CHUNK]  = sum[k*CHUNK +: CHUNK];
      end
    end
  end

  cla_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a    (chunk_a),
    .b    (chunk_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Next-state and datapath update decisions for IDLE / RUN / DONE.
  always_comb begin
    state_nxt = state;
    opa_nxt   = opa;
    opb_nxt   = opb;
    carry_nxt = carry;
    cnt_nxt   = cnt;
    sum_nxt   = sum;
    cout_nxt  = cout;
    ovf_nxt   = ovf;
    case (state)
      IDLE: begin
        if (in_valid) begin
          opa_nxt   = a;
          opb_nxt   = b_eff;
          carry_nxt = cin_eff;
          cnt_nxt   = {CW{1'b0}};
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      RUN: begin
        sum_nxt   = sum_merged;
        carry_nxt = slice_cout;
        if (cnt == LAST) begin
          cnt_nxt   = {CW{1'b0}};
          cout_nxt  = slice_cout;
          ovf_nxt   = signed_ovf(opa[WIDTH-1], opb[WIDTH-1], slice_sum[CHUNK-1]);
          state_nxt = DONE;
        end else begin
          cnt_nxt   = cnt + CW'(1);
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Operand, carry, counter and result registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opa   <= {WIDTH{1'b0}};
      opb   <= {WIDTH{1'b0}};
      carry <= 1'b0;
      cnt   <= {CW{1'b0}};
      sum   <= {WIDTH{1'b0}};
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      opa   <= opa_nxt;
      opb   <= opb_nxt;
      carry <= carry_nxt;
      cnt   <= cnt_nxt;
      sum   <= sum_nxt;
      cout  <= cout_nxt;
      ovf   <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_cla_wide_seq.sv
// Scoreboard bench for cla_wide_seq (default WIDTH=64, CHUNK=16).
// The driver pushes hand-computed results when a request is accepted;
// an independent monitor pops and compares on each output handshake.
module tb_cla_wide_seq;

  localparam int NCHUNK = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int total_cnt = 0;
  int pass_cnt  = 0;
  int cyc       = 0;
  logic prev_valid = 1'b0;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];

  cla_wide_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total_cnt++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  task automatic issue(input logic [63:0] av, input logic [63:0] bv, input logic c, input logic s,
                       input logic [63:0] e_sum, input logic e_cout, input logic e_ovf,
                       output int acc);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("issue_timeout");
      acc = -1;
    end else begin
      a         = av;
      b         = bv;
      cin       = c;
      sub       = s;
      in_valid  = 1'b1;
      acc       = cyc;
      e.sum     = e_sum;
      e.cout    = e_cout;
      e.ovf     = e_ovf;
      e.acc_cyc = cyc;
      sb.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
      a        = {$urandom, $urandom};
      b        = {$urandom, $urandom};
      cin      = 1'($urandom);
      sub      = 1'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) fail_now("drain_timeout");
  endtask

  // Monitor: latency on out_valid rise, result compare on each handshake.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && out_valid) begin
      if (!prev_valid) begin
        if (sb.size() > 0) check("latency", 64'(cyc - sb[0].acc_cyc), 64'(NCHUNK + 1));
        else fail_now("unexpected_out_valid");
      end
      if (out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_result");
        end else begin
          e = sb.pop_front();
          check("sum", sum, e.sum);
          check("cout", 64'(cout), 64'(e.cout));
          check("ovf", 64'(ovf), 64'(e.ovf));
        end
      end
    end
    prev_valid = rst_n && out_valid;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [63:0] va [8];
  logic [63:0] vb [8];
  logic        vc [8];
  logic [63:0] vs [8];
  logic        vco[8];
  logic        vov[8];

  initial begin
    int acc1;
    int acc2;
    int n;

    // a, b, cin -> sum, cout, ovf
    va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'h1; vc[0] = 1'b0; vs[0] = 64'h0;                  vco[0] = 1'b1; vov[0] = 1'b0;
    va[1] = 64'h7FFF_FFFF_FFFF_FFFF; vb[1] = 64'h1; vc[1] = 1'b0; vs[1] = 64'h8000_0000_0000_0000; vco[1] = 1'b0; vov[1] = 1'b1;
    va[2] = 64'h0000_0000_0000_FFFF; vb[2] = 64'h1; vc[2] = 1'b0; vs[2] = 64'h0000_0000_0001_0000; vco[2] = 1'b0; vov[2] = 1'b0;
    va[3] = 64'h0123_4567_89AB_CDEF; vb[3] = 64'hFEDC_BA98_7654_3210; vc[3] = 1'b0; vs[3] = 64'hFFFF_FFFF_FFFF_FFFF; vco[3] = 1'b0; vov[3] = 1'b0;
    va[4] = 64'h0123_4567_89AB_CDEF; vb[4] = 64'hFEDC_BA98_7654_3210; vc[4] = 1'b1; vs[4] = 64'h0;   vco[4] = 1'b1; vov[4] = 1'b0;
    va[5] = 64'h8000_0000_0000_0000; vb[5] = 64'h8000_0000_0000_0000; vc[5] = 1'b0; vs[5] = 64'h0; vco[5] = 1'b1; vov[5] = 1'b1;
    va[6] = 64'h0000_0000_FFFF_0000; vb[6] = 64'h0000_0000_0001_0000; vc[6] = 1'b0; vs[6] = 64'h0000_0001_0000_0000; vco[6] = 1'b0; vov[6] = 1'b0;
    va[7] = 64'h1234;                vb[7] = 64'h4321;                vc[7] = 1'b1; vs[7] = 64'h5556; vco[7] = 1'b0; vov[7] = 1'b0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a         = 64'h0;
    b         = 64'h0;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'(1'b1));
    check("rst_out_valid", 64'(out_valid), 64'(1'b0));
    check("rst_busy", 64'(busy), 64'(1'b0));
    check("rst_sum", sum, 64'h0);
    check("rst_cout", 64'(cout), 64'(1'b0));
    check("rst_ovf", 64'(ovf), 64'(1'b0));
    rst_n = 1'b1;

    // Directed table
    for (int i = 0; i < 8; i++) begin
      issue(va[i], vb[i], vc[i], 1'b0, vs[i], vco[i], vov[i], acc1);
      drain();
    end

    // Back-to-back requests: accepted NCHUNK+2 cycles apart
    issue(64'h0, 64'h0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0, acc1);
    issue(64'h2, 64'h3, 1'b0, 1'b0, 64'h5, 1'b0, 1'b0, acc2);
    check("issue_interval", 64'(acc2 - acc1), 64'(NCHUNK + 2));
    drain();

    // Consumer back-pressure: result held stable, no new acceptance
    out_ready = 1'b0;
    issue(64'h1234, 64'h4321, 1'b0, 1'b0, 64'h5555, 1'b0, 1'b0, acc1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) fail_now("hold_wait");
    for (int i = 0; i < 10; i++) begin
      check("hold_sum", sum, 64'h5555);
      check("hold_in_ready", 64'(in_ready), 64'(1'b0));
      @(negedge clk);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'(1'b1));
    drain();

    // Reset in the middle of RUN abandons the operation
    issue(64'h10, 64'h20, 1'b0, 1'b0, 64'h30, 1'b0, 1'b0, acc1);
    check("run_busy", 64'(busy), 64'(1'b1));
    check("run_in_ready", 64'(in_ready), 64'(1'b0));
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    sb.delete();
    check("abort_out_valid", 64'(out_valid), 64'(1'b0));
    check("abort_sum", sum, 64'h0);
    check("abort_in_ready", 64'(in_ready), 64'(1'b1));
    check("abort_busy", 64'(busy), 64'(1'b0));
    rst_n = 1'b1;
    issue(64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0, acc1);
    drain();

`ifdef CLA_SEQ_SUB_EN
    issue(64'h5, 64'h7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, acc1);
    drain();
    issue(64'h7, 64'h5, 1'b0, 1'b1, 64'h2, 1'b1, 1'b0, acc1);
    drain();
`else
    issue(64'h7, 64'h5, 1'b0, 1'b1, 64'hC, 1'b0, 1'b0, acc1);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
